// File: rtl/scan_select_sequencer.sv
// Scan sequencer feeding a 3-to-8 one-hot decoder.
// Walks enabled mask channels, holding each for dwell+1 cycles.
module scan_select_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               active,
  output logic               step,
  output logic               wrap
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [2:0]         r_sel;
  logic [2:0]         w_sel_nx;
  logic               r_active;
  logic               w_active_nx;
  logic               r_step;
  logic               w_step_nx;
  logic               r_wrap;
  logic               w_wrap_nx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nx;
  logic [2:0]         w_lowest;
  logic [2:0]         w_next;
  logic               w_any;

  function automatic logic [2:0] f_lowest(
    input logic [7:0] m
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Search s+1..7 then 0..s; lowest offset wins, offset 8 maps back to s.
  function automatic logic [2:0] f_next(
    input logic [7:0] m,
    input logic [2:0] s
  );
    logic [2:0] r;
    logic [2:0] idx;
    r = s;
    for (int i = 8; i >= 1; i--) begin
      idx = s + 3'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign w_any    = |mask;
  assign w_lowest = f_lowest(mask);
  assign w_next   = f_next(mask, r_sel);

  always_comb begin
    w_state_nx  = r_state;
    w_sel_nx    = r_sel;
    w_active_nx = r_active;
    w_step_nx   = 1'b0;
    w_wrap_nx   = 1'b0;
    w_cnt_nx    = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_sel_nx    = 3'd0;
        w_active_nx = 1'b0;
        w_cnt_nx    = '0;
        if (en && w_any) begin
          w_state_nx  = SCAN;
          w_sel_nx    = w_lowest;
          w_active_nx = 1'b1;
          w_step_nx   = 1'b1;
        end
      end
      SCAN: begin
        if (!en || !w_any) begin
          w_state_nx  = IDLE;
          w_sel_nx    = 3'd0;
          w_active_nx = 1'b0;
          w_cnt_nx    = '0;
        end else if (!mask[r_sel] || (r_cnt >= dwell)) begin
          w_sel_nx  = w_next;
          w_cnt_nx  = '0;
          w_step_nx = 1'b1;
          w_wrap_nx = (w_next <= r_sel);
        end else begin
          w_cnt_nx = r_cnt + DWELL_W'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= 3'd0;
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_sel    <= w_sel_nx;
      r_active <= w_active_nx;
      r_step   <= w_step_nx;
      r_wrap   <= w_wrap_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  assign sel    = r_sel;
  assign active = r_active;
  assign step   = r_step;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed bench for scan_select_sequencer.
// Observed tuple is {active, sel[2:0], step, wrap}.
module tb_scan_select_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       active;
  logic       step;
  logic       wrap;
  logic [5:0] obs;

  int vecs;
  int errs;

  scan_select_sequencer #(
    .DWELL_W(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mask  (mask),
    .dwell (dwell),
    .sel   (sel),
    .active(active),
    .step  (step),
    .wrap  (wrap)
  );

  assign obs = {active, sel, step, wrap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b0;
    mask  = 8'h00;
    dwell = 8'd0;
    tick();
    tick();
    vecs++;
    if (obs !== 6'b0) begin
      errs++;
      $display("FAIL reset got=%b exp=%b", obs, 6'b0);
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (obs !== 6'b0) begin
      errs++;
      $display("FAIL idle_en0 got=%b exp=%b", obs, 6'b0);
    end
  endtask

  task automatic test_full_scan();
    logic [5:0] exp;
    do_reset();
    mask  = 8'hFF;
    dwell = 8'd2;
    en    = 1'b1;
    tick();
    exp = {1'b1, 3'd0, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL full_start got=%b exp=%b", obs, exp);
    end
    for (int h = 0; h < 2; h++) begin
      tick();
      exp = {1'b1, 3'd0, 1'b0, 1'b0};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL full_hold0 h=%0d got=%b exp=%b", h, obs, exp);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b1, 3'(k % 8), 1'b1, (k == 8)};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL full_step k=%0d got=%b exp=%b", k, obs, exp);
      end
      for (int h = 0; h < 2; h++) begin
        tick();
        exp = {1'b1, 3'(k % 8), 1'b0, 1'b0};
        vecs++;
        if (obs !== exp) begin
          errs++;
          $display("FAIL full_hold k=%0d h=%0d got=%b exp=%b", k, h, obs, exp);
        end
      end
    end
  endtask

  task automatic test_sparse();
    logic [2:0] seq [7];
    logic       wr  [7];
    logic [5:0] exp;
    seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7, 3'd2};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    mask  = 8'b1010_0100;
    dwell = 8'd0;
    en    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp = {1'b1, seq[i], 1'b1, wr[i]};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL sparse i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_single();
    logic [5:0] exp;
    do_reset();
    mask  = 8'b0001_0000;
    dwell = 8'd1;
    en    = 1'b1;
    tick();
    exp = {1'b1, 3'd4, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL single_start got=%b exp=%b", obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b1, 3'd4, 1'b0, 1'b0};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL single_hold i=%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
      exp = {1'b1, 3'd4, 1'b1, 1'b1};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL single_wrap i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [5:0] exp;
    do_reset();
    mask  = 8'h08;
    dwell = 8'd5;
    en    = 1'b1;
    tick();
    mask = 8'h0F;
    tick();
    exp = {1'b1, 3'd3, 1'b0, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL wd_hold got=%b exp=%b", obs, exp);
    end
    mask = 8'h07;
    tick();
    exp = {1'b1, 3'd0, 1'b1, 1'b1};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL wd_jump got=%b exp=%b", obs, exp);
    end
    for (int h = 0; h < 5; h++) begin
      tick();
      exp = {1'b1, 3'd0, 1'b0, 1'b0};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL wd_cnt h=%0d got=%b exp=%b", h, obs, exp);
      end
    end
    tick();
    exp = {1'b1, 3'd1, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL wd_next got=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_dwell_lower();
    logic [5:0] exp;
    for (int h = 0; h < 3; h++) begin
      tick();
      exp = {1'b1, 3'd1, 1'b0, 1'b0};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL dl_hold h=%0d got=%b exp=%b", h, obs, exp);
      end
    end
    dwell = 8'd1;
    tick();
    exp = {1'b1, 3'd2, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL dl_cut got=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_disable();
    logic [5:0] exp;
    en = 1'b0;
    tick();
    vecs++;
    if (obs !== 6'b0) begin
      errs++;
      $display("FAIL dis_en got=%b exp=%b", obs, 6'b0);
    end
    mask = 8'h30;
    en   = 1'b1;
    tick();
    exp = {1'b1, 3'd4, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL dis_resume got=%b exp=%b", obs, exp);
    end
    mask = 8'h00;
    tick();
    vecs++;
    if (obs !== 6'b0) begin
      errs++;
      $display("FAIL dis_mask0 got=%b exp=%b", obs, 6'b0);
    end
    mask = 8'h30;
    tick();
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL dis_resume2 got=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    dwell = 8'd3;
    tick();
    exp = {1'b1, 3'd4, 1'b0, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL rm_hold got=%b exp=%b", obs, exp);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (obs !== 6'b0) begin
      errs++;
      $display("FAIL rm_reset got=%b exp=%b", obs, 6'b0);
    end
    rst = 1'b0;
    tick();
    exp = {1'b1, 3'd4, 1'b1, 1'b0};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL rm_restart got=%b exp=%b", obs, exp);
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    rst   = 1'b1;
    en    = 1'b0;
    mask  = 8'h00;
    dwell = 8'd0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_single();
    test_withdraw();
    test_dwell_lower();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
